// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage.
// Contents: opcode constants, instruction field offsets and widths, the one-hot
// instruction class encoding, and two helpers:
//   decode_cls(opcode)  - instruction class (R / I / JI / JII)
//   opb_uses_rd(opcode) - store/branch forms whose second operand comes from rd
package decode_pkg;

    // Opcodes that affect classification or operand routing
    localparam logic [4:0] OpR     = 5'b00000;
    localparam logic [4:0] OpJumpA = 5'b00001;
    localparam logic [4:0] OpJumpB = 5'b00011;
    localparam logic [4:0] OpJumpC = 5'b10101;
    localparam logic [4:0] OpJumpD = 5'b10110;
    localparam logic [4:0] OpJr    = 5'b00100;
    localparam logic [4:0] OpBne   = 5'b00010;
    localparam logic [4:0] OpBlt   = 5'b00110;
    localparam logic [4:0] OpSw    = 5'b00111;

    // Field layout of the 32-bit instruction word
    localparam int unsigned OpcodeW   = 5;
    localparam int unsigned OpcodeLsb = 27;
    localparam int unsigned RdLsb     = 22;
    localparam int unsigned RsLsb     = 17;
    localparam int unsigned RtLsb     = 12;
    localparam int unsigned ShamtW    = 5;
    localparam int unsigned ShamtLsb  = 7;
    localparam int unsigned AluopW    = 5;
    localparam int unsigned AluopLsb  = 2;

    // One-hot class, bit order {R, I, JI, JII}
    typedef enum logic [3:0] {
        ClsJii = 4'b0001,
        ClsJi  = 4'b0010,
        ClsI   = 4'b0100,
        ClsR   = 4'b1000
    } cls_e;

    function automatic cls_e decode_cls(input logic [4:0] opcode);
        cls_e cls;
        case (opcode)
            OpR:                                 cls = ClsR;
            OpJumpA, OpJumpB, OpJumpC, OpJumpD:  cls = ClsJi;
            OpJr:                                cls = ClsJii;
            default:                             cls = ClsI;
        endcase
        return cls;
    endfunction

    function automatic logic opb_uses_rd(input logic [4:0] opcode);
        return (opcode == OpSw) || (opcode == OpBne) || (opcode == OpBlt);
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file for the decode stage: NREGS x DATA_W, one write port, two read ports.
// r0 always reads zero and ignores writes. Reads see a same-cycle write (write-through).
// Ports:
//   clk, clr_n          clock, async active-low reset (clears every register)
//   we, waddr, wdata    write port
//   raddr_a, rdata_a    read port A
//   raddr_b, rdata_b    read port B
module decode_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int unsigned NRegs = 2 ** REG_AW;

    logic [DATA_W-1:0] regs [NRegs];
    logic              wr_live;

    assign wr_live = we && (waddr != '0);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int unsigned i = 0; i < NRegs; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = '0;
        if (raddr_a != '0) begin
            rdata_a = (wr_live && (waddr == raddr_a)) ? wdata : regs[raddr_a];
        end
    end

    always_comb begin
        rdata_b = '0;
        if (raddr_b != '0) begin
            rdata_b = (wr_live && (waddr == raddr_b)) ? wdata : regs[raddr_b];
        end
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage between fetch and execute.
// Slices the instruction into fields, classifies it, reads operands from the register
// file (with writeback bypass) and registers everything in a single output slot.
// Ports:
//   clk, clr_n                         clock, async active-low reset
//   in_valid/in_ready/in_pc/in_instr   fetch side handshake and payload
//   flush                              kill held and incoming instruction
//   wb_en/wb_rd/wb_data                writeback into the register file
//   out_valid/out_ready                execute side handshake
//   out_pc, out_cls, out_opcode, out_rd, out_rs, out_rt, out_shamt, out_aluop,
//   out_imm (sign-extended), out_target (zero-extended), out_opA, out_opB
module decode_stage_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned IMM_W   = 17,
    parameter int unsigned TGT_W   = 27,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    input  logic               wb_en,
    input  logic [REG_AW-1:0]  wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_pc,
    output logic [3:0]         out_cls,
    output logic [4:0]         out_opcode,
    output logic [REG_AW-1:0]  out_rd,
    output logic [REG_AW-1:0]  out_rs,
    output logic [REG_AW-1:0]  out_rt,
    output logic [4:0]         out_shamt,
    output logic [4:0]         out_aluop,
    output logic [DATA_W-1:0]  out_imm,
    output logic [DATA_W-1:0]  out_target,
    output logic [DATA_W-1:0]  out_opA,
    output logic [DATA_W-1:0]  out_opB
);

    import decode_pkg::*;

    // Incoming fields
    logic [4:0]        in_opcode;
    logic [REG_AW-1:0] in_rd;
    logic [REG_AW-1:0] in_rs;
    logic [REG_AW-1:0] in_rt;
    logic [REG_AW-1:0] in_opb_src;
    logic [4:0]        in_shamt;
    logic [4:0]        in_aluop;
    logic [DATA_W-1:0] in_imm;
    logic [DATA_W-1:0] in_target;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    assign in_opcode  = in_instr[OpcodeLsb +: OpcodeW];
    assign in_rd      = in_instr[RdLsb +: REG_AW];
    assign in_rs      = in_instr[RsLsb +: REG_AW];
    assign in_rt      = in_instr[RtLsb +: REG_AW];
    assign in_shamt   = in_instr[ShamtLsb +: ShamtW];
    assign in_aluop   = in_instr[AluopLsb +: AluopW];
    assign in_imm     = {{(DATA_W - IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
    assign in_target  = {{(DATA_W - TGT_W){1'b0}}, in_instr[TGT_W-1:0]};
    assign in_opb_src = opb_uses_rd(in_opcode) ? in_rd : in_rt;

    decode_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk     (clk),
        .clr_n   (clr_n),
        .we      (wb_en),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (in_rs),
        .rdata_a (rd_a),
        .raddr_b (in_opb_src),
        .rdata_b (rd_b)
    );

    // Handshake
    logic accept;
    logic consume;
    logic held;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign consume  = out_valid && out_ready;
    assign held     = out_valid && !out_ready;

    // A held instruction read its operands before this writeback landed, so patch them.
    logic [REG_AW-1:0] held_opb_src;
    logic              refresh_a;
    logic              refresh_b;

    assign held_opb_src = opb_uses_rd(out_opcode) ? out_rd : out_rt;
    assign refresh_a    = wb_en && (wb_rd == out_rs) && (out_rs != '0);
    assign refresh_b    = wb_en && (wb_rd == held_opb_src) && (held_opb_src != '0);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_cls    <= '0;
            out_opcode <= '0;
            out_rd     <= '0;
            out_rs     <= '0;
            out_rt     <= '0;
            out_shamt  <= '0;
            out_aluop  <= '0;
            out_imm    <= '0;
            out_target <= '0;
            out_opA    <= '0;
            out_opB    <= '0;
        end else if (flush) begin
            // Payload is left stale; nothing downstream looks at it while invalid.
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_pc     <= in_pc;
            out_cls    <= decode_cls(in_opcode);
            out_opcode <= in_opcode;
            out_rd     <= in_rd;
            out_rs     <= in_rs;
            out_rt     <= in_rt;
            out_shamt  <= in_shamt;
            out_aluop  <= in_aluop;
            out_imm    <= in_imm;
            out_target <= in_target;
            out_opA    <= rd_a;
            out_opB    <= rd_b;
        end else if (consume) begin
            out_valid <= 1'b0;
        end else if (held) begin
            if (refresh_a) begin
                out_opA <= wb_data;
            end
            if (refresh_b) begin
                out_opB <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [3:0]  out_cls;
    logic [4:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_shamt;
    logic [4:0]  out_aluop;
    logic [31:0] out_imm;
    logic [31:0] out_target;
    logic [31:0] out_opA;
    logic [31:0] out_opB;

    always #5 clk = ~clk;

    decode_stage_pipe dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .flush      (flush),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_cls    (out_cls),
        .out_opcode (out_opcode),
        .out_rd     (out_rd),
        .out_rs     (out_rs),
        .out_rt     (out_rt),
        .out_shamt  (out_shamt),
        .out_aluop  (out_aluop),
        .out_imm    (out_imm),
        .out_target (out_target),
        .out_opA    (out_opA),
        .out_opB    (out_opB)
    );

    // Expected static content of one accepted instruction; operands are looked up by
    // register number in the model register file when the slot is observed.
    typedef struct {
        logic [31:0] pc;
        logic [3:0]  cls;
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [4:0]  aluop;
        logic [31:0] imm;
        logic [31:0] target;
        logic [4:0]  srca;
        logic [4:0]  srcb;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mrf[32];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t make_exp(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        int   s;
        int   op;
        op       = int'(instr >> 27);
        e.pc     = pc;
        e.opcode = 5'(op);
        e.rd     = 5'(instr >> 22);
        e.rs     = 5'(instr >> 17);
        e.rt     = 5'(instr >> 12);
        e.shamt  = 5'(instr >> 7);
        e.aluop  = 5'(instr >> 2);
        case (op)
            0:             e.cls = 4'b1000;
            1, 3, 21, 22:  e.cls = 4'b0010;
            4:             e.cls = 4'b0001;
            default:       e.cls = 4'b0100;
        endcase
        s = int'(instr & 32'h0001_FFFF);
        if (s >= 65536) s = s - 131072;
        e.imm    = 32'(s);
        e.target = instr & 32'h07FF_FFFF;
        e.srca   = e.rs;
        e.srcb   = (op == 7 || op == 2 || op == 6) ? e.rd : e.rt;
        return e;
    endfunction

    function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt,
                                       input int low);
        return {5'(op), 5'(rd), 5'(rs), 5'(rt), 12'(low)};
    endfunction

    // Reference model: slot occupancy and register file, advanced on each edge.
    always @(posedge clk) begin
        if (clr_n) begin
            logic rdy;
            logic acc;
            rdy = (sb.size() == 0) || out_ready;
            acc = in_valid && rdy && !flush;
            if (flush) begin
                sb.delete();
            end else if (sb.size() != 0 && out_ready) begin
                void'(sb.pop_front());
            end
            if (acc) sb.push_back(make_exp(in_pc, in_instr));
            if (wb_en && wb_rd != 5'd0) mrf[wb_rd] = wb_data;
        end
    end

    // Monitor: mid-cycle comparison of whatever the slot presents.
    always @(negedge clk) begin
        if (clr_n) begin
            check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            check("in_ready", 32'(in_ready), 32'((sb.size() == 0) || out_ready));
            if (out_valid && sb.size() != 0) begin
                exp_t e;
                e = sb[0];
                check("out_pc", out_pc, e.pc);
                check("out_cls", 32'(out_cls), 32'(e.cls));
                check("out_opcode", 32'(out_opcode), 32'(e.opcode));
                check("out_rd", 32'(out_rd), 32'(e.rd));
                check("out_rs", 32'(out_rs), 32'(e.rs));
                check("out_rt", 32'(out_rt), 32'(e.rt));
                check("out_shamt", 32'(out_shamt), 32'(e.shamt));
                check("out_aluop", 32'(out_aluop), 32'(e.aluop));
                check("out_imm", out_imm, e.imm);
                check("out_target", out_target, e.target);
                check("out_opA", out_opA, mrf[e.srca]);
                check("out_opB", out_opB, mrf[e.srcb]);
            end
        end
    end

    task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                         input logic fl, input logic we, input int wr, input logic [31:0] wd,
                         input logic ordy);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr;
        flush     = fl;
        wb_en     = we;
        wb_rd     = 5'(wr);
        wb_data   = wd;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b1);
    endtask

    task automatic clear_model();
        sb.delete();
        foreach (mrf[i]) mrf[i] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ops[4];
        clear_model();
        clr_n     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        flush     = 1'b0;
        wb_en     = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        out_ready = 1'b0;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_opA", out_opA, 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;

        // Bypass: writeback of r3 in the accept cycle of add r1,r3,r4
        drive(1'b1, 32'h100, mk(0, 1, 3, 4, 0), 1'b0, 1'b1, 3, 32'hDEAD_BEEF, 1'b1);
        check("bypass opA", out_opA, 32'hDEAD_BEEF);
        check("bypass cls", 32'(out_cls), 32'h8);
        idle();

        // Stall and refresh of held rs=5
        drive(1'b1, 32'h200, mk(9, 2, 5, 6, 12'hABC), 1'b0, 1'b0, 0, 32'h0, 1'b0);
        drive(1'b1, 32'h204, mk(0, 1, 1, 1, 0), 1'b0, 1'b1, 5, 32'h0000_1234, 1'b0);
        check("refresh opA", out_opA, 32'h0000_1234);
        check("stall in_ready", 32'(in_ready), 32'd0);
        check("stall pc", out_pc, 32'h200);
        // Flush while held and offered a new instruction
        drive(1'b1, 32'h208, mk(0, 1, 2, 3, 0), 1'b1, 1'b0, 0, 32'h0, 1'b0);
        check("flush out_valid", 32'(out_valid), 32'd0);
        drive(1'b1, 32'h20C, mk(5, 3, 3, 3, 0), 1'b0, 1'b0, 0, 32'h0, 1'b1);
        check("post-flush accept", out_pc, 32'h20C);

        // Classes, negative immediate, back-to-back throughput
        ops[0] = 5'b00000; ops[1] = 5'b00101; ops[2] = 5'b00011; ops[3] = 5'b00100;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), {ops[i], 10'h0, 17'h1FFFF}, 1'b0, 1'b0, 0,
                  32'h0, 1'b1);
            check("throughput pc", out_pc, 32'h300 + 32'(4 * i));
        end
        check("imm sign-ext", out_imm, 32'hFFFF_FFFF);

        // r0 stays zero
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 0, 32'h0000_0055, 1'b1);
        drive(1'b1, 32'h400, mk(0, 1, 0, 0, 0), 1'b0, 1'b0, 0, 32'h0, 1'b1);
        check("r0 opA", out_opA, 32'd0);

        // Randomised traffic
        for (int n = 0; n < 2000; n++) begin
            drive(($urandom % 4) != 0, $urandom,
                  mk(int'($urandom % 32), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), int'($urandom % 4096)) ^ ($urandom & 32'h0001_8000),
                  ($urandom % 16) == 0, ($urandom % 2) == 0, int'($urandom_range(0, 7)),
                  $urandom, ($urandom % 4) != 0);
        end

        // Reset in the middle of a held instruction
        drive(1'b1, 32'h500, mk(0, 1, 2, 3, 0), 1'b0, 1'b1, 2, 32'h7777_7777, 1'b0);
        clr_n = 1'b0;
        #1;
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset out_opA", out_opA, 32'd0);
        check("midreset out_pc", out_pc, 32'd0);
        clear_model();
        @(posedge clk);
        #1;
        clr_n = 1'b1;

        for (int n = 0; n < 300; n++) begin
            drive(($urandom % 3) != 0, $urandom,
                  mk(int'($urandom % 32), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), int'($urandom % 4096)),
                  ($urandom % 20) == 0, ($urandom % 2) == 0, int'($urandom_range(0, 7)),
                  $urandom, ($urandom % 3) != 0);
        end

        repeat (3) idle();
        check("drained", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
